// File: rtl/squares_pkg.sv
// Shared types and default geometry for the ping-pong frame store and its scanout controller.
package squares_pkg;

  localparam int unsigned A_DEFAULT = 9;
  localparam int unsigned S_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWAP   = 3'd1,
    SETTLE = 3'd2,
    SCAN   = 3'd3,
    DRAIN  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/buffer_scanout_if.sv
// Valid/ready pixel stream from the scanout controller toward the display pipeline.
interface buffer_scanout_if #(
  parameter int unsigned S = 24
) ();

  logic [S-1:0] pix_data;
  logic         pix_valid;
  logic         pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a registered head; absorbs the one-cycle read latency under backpressure.
module skid_fifo2 #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         valid_q, valid_d;
  logic         pop_ok;
  logic [1:0]   occ;

  // Pop shifts slot1 forward; a push lands in the first free slot after the pop.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pop_ok  = pop && (count_q != 2'd0);
    occ     = count_q - 2'(pop_ok);
    if (pop_ok) slot0_d = slot1_q;
    if (push) begin
      if (occ == 2'd0) slot0_d = push_data;
      else             slot1_d = push_data;
    end
    count_d = occ + 2'(push);
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head_data  = slot0_q;
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/buffer_scanout.sv
// Read-side scanout controller for the ping-pong frame store: swap, settle, stream ENTRIES words.
// Define BUFFER_SCANOUT_AUTOSTART_EN to chain frames back-to-back after the first start.
module buffer_scanout
  import squares_pkg::*;
#(
  parameter int unsigned A       = A_DEFAULT,
  parameter int unsigned S       = S_DEFAULT,
  parameter int unsigned ENTRIES = 2**A
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  output logic             swap,
  output logic [A-1:0]     address_read,
  input  logic [S-1:0]     data_read,
  output logic             busy,
  output logic             frame_done,
  buffer_scanout_if.master pix
);

  localparam logic [A:0] LAST = (A+1)'(ENTRIES - 1);

  scan_state_t state_q, state_d;
  logic [A:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;
  logic        swap_q, swap_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic [S-1:0] head_data;
  logic         head_valid;
  logic [1:0]   fifo_count;
  logic         pop;
  logic [1:0]   occ_after;

  skid_fifo2 #(.W(S)) u_fifo (
    .clk        (clock),
    .rst_n      (resetn),
    .push       (inflight_q),
    .push_data  (data_read),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign pop       = head_valid && pix.pix_ready;
  assign occ_after = fifo_count - 2'(pop);

  // Issue only when the word returning next cycle is guaranteed a free slot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    inflight_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = SWAP;
      SWAP:   state_d = SETTLE;
      SETTLE: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (({1'b0, occ_after} + {2'b00, inflight_q}) <= 3'd1) begin
          inflight_d = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + (A+1)'(1);
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (occ_after == 2'd0)) begin
          frame_done_d = 1'b1;
`ifdef BUFFER_SCANOUT_AUTOSTART_EN
          state_d = SWAP;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    swap_d = (state_d == SWAP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      swap_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      swap_q       <= swap_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign swap          = swap_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign address_read  = cnt_q[A-1:0];
  assign pix.pix_data  = head_data;
  assign pix.pix_valid = head_valid;

endmodule

// File: tb/tb_buffer_scanout.sv
// Directed bench for buffer_scanout: three instances (16, 1 and 512 words) over a data=address+100 memory.
module tb_buffer_scanout;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  logic        start16, swap16, busy16, fd16;
  logic [8:0]  addr16;
  logic [23:0] dr16;
  logic        start1, swap1, busy1, fd1;
  logic [8:0]  addr1;
  logic [23:0] dr1;
  logic        start512, swap512, busy512, fd512;
  logic [8:0]  addr512;
  logic [23:0] dr512;

  buffer_scanout_if #(.S(24)) if16 ();
  buffer_scanout_if #(.S(24)) if1 ();
  buffer_scanout_if #(.S(24)) if512 ();

  buffer_scanout #(.A(9), .S(24), .ENTRIES(16)) dut16 (
    .clock(clock), .resetn(resetn), .start(start16), .swap(swap16), .address_read(addr16),
    .data_read(dr16), .busy(busy16), .frame_done(fd16), .pix(if16)
  );
  buffer_scanout #(.A(9), .S(24), .ENTRIES(1)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .swap(swap1), .address_read(addr1),
    .data_read(dr1), .busy(busy1), .frame_done(fd1), .pix(if1)
  );
  buffer_scanout #(.A(9), .S(24), .ENTRIES(512)) dut512 (
    .clock(clock), .resetn(resetn), .start(start512), .swap(swap512), .address_read(addr512),
    .data_read(dr512), .busy(busy512), .frame_done(fd512), .pix(if512)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read frame store model: one cycle latency.
  always @(posedge clock) begin
    dr16  <= 24'(addr16) + 24'd100;
    dr1   <= 24'(addr1) + 24'd100;
    dr512 <= 24'(addr512) + 24'd100;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start16 = 1'b0; start1 = 1'b0; start512 = 1'b0;
    if16.pix_ready = 1'b1; if1.pix_ready = 1'b1; if512.pix_ready = 1'b1;
    tick(); tick();
    checks++; if (swap16 !== 1'b0) begin failures++; $display("FAIL reset_swap: got %0b want 0", swap16); end
    checks++; if (addr16 !== 9'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", addr16); end
    checks++; if (if16.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", if16.pix_valid); end
    checks++; if (if16.pix_data !== 24'd0) begin failures++; $display("FAIL reset_data: got %0d want 0", if16.pix_data); end
    checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy16); end
    checks++; if (fd16 !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", fd16); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    start16 = 1'b1;
    tick();
    checks++; if (swap16 !== 1'b1) begin failures++; $display("FAIL stream_swap: got %0b want 1", swap16); end
    start16 = 1'b0;
    tick();
    checks++; if (swap16 !== 1'b0 || busy16 !== 1'b1) begin failures++; $display("FAIL stream_settle: swap %0b busy %0b want 0 1", swap16, busy16); end
    tick();
    checks++; if (if16.pix_valid !== 1'b0 || addr16 !== 9'd0) begin failures++; $display("FAIL stream_scan0: valid %0b addr %0d want 0 0", if16.pix_valid, addr16); end
    tick();
    checks++; if (if16.pix_valid !== 1'b0) begin failures++; $display("FAIL stream_scan1: valid %0b want 0", if16.pix_valid); end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (if16.pix_valid !== 1'b1 || if16.pix_data !== 24'(100 + i)) begin
        failures++; $display("FAIL stream_word%0d: valid %0b data %0d want 1 %0d", i, if16.pix_valid, if16.pix_data, 100 + i);
      end
    end
    tick();
    checks++; if (fd16 !== 1'b1 || if16.pix_valid !== 1'b0 || busy16 !== 1'b0) begin
      failures++; $display("FAIL stream_done: done %0b valid %0b busy %0b want 1 0 0", fd16, if16.pix_valid, busy16); end
    tick();
    checks++; if (fd16 !== 1'b0) begin failures++; $display("FAIL stream_done_pulse: got %0b want 0", fd16); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    bit seen_done = 0;
    bit prev_stall = 0;
    logic [23:0] prev_data = '0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (prev_stall) begin
        checks++;
        if (if16.pix_valid !== 1'b1 || if16.pix_data !== prev_data) begin
          failures++; $display("FAIL bp_stable: valid %0b data %0d want 1 %0d", if16.pix_valid, if16.pix_data, prev_data);
        end
      end
      checks++;
      if (dut16.fifo_count > 2'd2) begin failures++; $display("FAIL bp_occupancy: got %0d want <=2", dut16.fifo_count); end
      if (fd16 === 1'b1) begin seen_done = 1; break; end
      if16.pix_ready = 1'($urandom_range(0, 1));
      if (if16.pix_valid === 1'b1 && if16.pix_ready === 1'b1) begin
        checks++;
        if (if16.pix_data !== 24'(100 + idx)) begin
          failures++; $display("FAIL bp_word%0d: got %0d want %0d", idx, if16.pix_data, 100 + idx);
        end
        idx++;
      end
      prev_stall = (if16.pix_valid === 1'b1) && (if16.pix_ready === 1'b0);
      prev_data  = if16.pix_data;
      tick();
    end
    checks++; if (!seen_done || idx != 16) begin failures++; $display("FAIL bp_count: done %0b words %0d want 1 16", seen_done, idx); end
    if16.pix_ready = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if16.pix_valid !== 1'b1 || if16.pix_data !== 24'(100 + i)) begin
        failures++; $display("FAIL stall_pre%0d: data %0d want %0d", i, if16.pix_data, 100 + i);
      end
    end
    tick();
    if16.pix_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (if16.pix_valid !== 1'b1 || if16.pix_data !== 24'd105 || addr16 !== 9'd7) begin
        failures++; $display("FAIL stall_hold%0d: valid %0b data %0d addr %0d want 1 105 7", k, if16.pix_valid, if16.pix_data, addr16);
      end
    end
    checks++; if (dut16.fifo_count !== 2'd2) begin failures++; $display("FAIL stall_buffered: got %0d want 2", dut16.fifo_count); end
    if16.pix_ready = 1'b1;
    for (int i = 5; i < 16; i++) begin
      checks++;
      if (if16.pix_valid !== 1'b1 || if16.pix_data !== 24'(100 + i)) begin
        failures++; $display("FAIL stall_resume%0d: valid %0b data %0d want 1 %0d", i, if16.pix_valid, if16.pix_data, 100 + i);
      end
      tick();
    end
    checks++; if (fd16 !== 1'b1) begin failures++; $display("FAIL stall_done: got %0b want 1", fd16); end
    tick();
  endtask

  task automatic test_start_ignored();
    int swaps = 0;
    bit seen_done = 0;
    start16 = 1'b1;
    tick();
    for (int n = 0; n < 100; n++) begin
      if (swap16 === 1'b1) swaps++;
      if (fd16 === 1'b1) begin seen_done = 1; break; end
      tick();
    end
    checks++; if (!seen_done || swaps != 1) begin failures++; $display("FAIL ign_swaps: done %0b swaps %0d want 1 1", seen_done, swaps); end
    checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL ign_idle: busy %0b want 0", busy16); end
    tick();
    checks++; if (swap16 !== 1'b1) begin failures++; $display("FAIL ign_restart: swap %0b want 1", swap16); end
    start16 = 1'b0;
    swaps = 1;
    seen_done = 0;
    tick();
    for (int n = 0; n < 100; n++) begin
      if (swap16 === 1'b1) swaps++;
      if (fd16 === 1'b1) begin seen_done = 1; break; end
      tick();
    end
    checks++; if (!seen_done || swaps != 1) begin failures++; $display("FAIL ign_frame2: done %0b swaps %0d want 1 1", seen_done, swaps); end
    tick();
  endtask

  task automatic test_mid_reset();
    int idx = 0;
    bit seen_done = 0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (if16.pix_valid === 1'b1 && if16.pix_data === 24'd103) break;
      tick();
    end
    checks++; if (if16.pix_data !== 24'd103) begin failures++; $display("FAIL mr_reach: data %0d want 103", if16.pix_data); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({swap16, busy16, fd16, if16.pix_valid} !== 4'b0 || addr16 !== 9'd0 || if16.pix_data !== 24'd0) begin
      failures++; $display("FAIL mr_clear: swap %0b busy %0b done %0b valid %0b addr %0d data %0d want all 0",
                           swap16, busy16, fd16, if16.pix_valid, addr16, if16.pix_data);
    end
    tick();
    resetn = 1'b1;
    tick(); tick(); tick();
    checks++; if (fd16 !== 1'b0 || busy16 !== 1'b0) begin failures++; $display("FAIL mr_nodone: done %0b busy %0b want 0 0", fd16, busy16); end
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (if16.pix_valid === 1'b1) begin
        checks++;
        if (if16.pix_data !== 24'(100 + idx)) begin
          failures++; $display("FAIL mr_word%0d: got %0d want %0d", idx, if16.pix_data, 100 + idx);
        end
        idx++;
      end
      if (fd16 === 1'b1) begin seen_done = 1; break; end
      tick();
    end
    checks++; if (!seen_done || idx != 16) begin failures++; $display("FAIL mr_frame: done %0b words %0d want 1 16", seen_done, idx); end
    tick();
  endtask

  task automatic test_entries1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++; if (swap1 !== 1'b1) begin failures++; $display("FAIL e1_swap: got %0b want 1", swap1); end
    tick(); tick();
    checks++; if (addr1 !== 9'd0 || if1.pix_valid !== 1'b0) begin failures++; $display("FAIL e1_scan: addr %0d valid %0b want 0 0", addr1, if1.pix_valid); end
    tick();
    checks++; if (busy1 !== 1'b1 || addr1 !== 9'd0 || if1.pix_valid !== 1'b0) begin
      failures++; $display("FAIL e1_drain: busy %0b addr %0d valid %0b want 1 0 0", busy1, addr1, if1.pix_valid); end
    tick();
    checks++; if (if1.pix_valid !== 1'b1 || if1.pix_data !== 24'd100) begin
      failures++; $display("FAIL e1_word: valid %0b data %0d want 1 100", if1.pix_valid, if1.pix_data); end
    tick();
    checks++; if (fd1 !== 1'b1 || if1.pix_valid !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL e1_done: done %0b valid %0b busy %0b want 1 0 0", fd1, if1.pix_valid, busy1); end
    tick();
  endtask

  task automatic test_entries512();
    int idx = 0;
    bit seen_done = 0;
    int bad = 0;
    start512 = 1'b1;
    tick();
    start512 = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (if512.pix_valid === 1'b1) begin
        if (if512.pix_data !== 24'(100 + idx)) begin
          bad++;
          if (bad < 5) $display("FAIL e512_word%0d: got %0d want %0d", idx, if512.pix_data, 100 + idx);
        end
        idx++;
      end
      if (fd512 === 1'b1) begin seen_done = 1; break; end
      tick();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL e512_data: bad words %0d want 0", bad); end
    checks++; if (!seen_done || idx != 512) begin failures++; $display("FAIL e512_count: done %0b words %0d want 1 512", seen_done, idx); end
    checks++; if (addr512 !== 9'd0 || busy512 !== 1'b0) begin failures++; $display("FAIL e512_end: addr %0d busy %0b want 0 0", addr512, busy512); end
    tick();
  endtask

  task automatic test_autostart();
    int frames = 0;
    int idx = 0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (if16.pix_valid === 1'b1) begin
        checks++;
        if (if16.pix_data !== 24'(100 + idx)) begin
          failures++; $display("FAIL auto_word%0d_%0d: got %0d want %0d", frames, idx, if16.pix_data, 100 + idx);
        end
        idx++;
      end
      if (fd16 === 1'b1) begin
        checks++;
        if (swap16 !== 1'b1 || idx != 16) begin
          failures++; $display("FAIL auto_chain%0d: swap %0b words %0d want 1 16", frames, swap16, idx);
        end
        frames++;
        idx = 0;
        if (frames == 3) break;
      end
      tick();
    end
    checks++; if (frames != 3) begin failures++; $display("FAIL auto_frames: got %0d want 3", frames); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
`ifdef BUFFER_SCANOUT_AUTOSTART_EN
    test_autostart();
`else
    test_streaming();
    test_backpressure();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_entries1();
    test_entries512();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
